// File: rtl/iob_merge_arb.sv
// Round-robin grant arbiter driving the select input of the N-to-1 IOb merge.
// Latency: grant registered one cycle after a request is seen in IDLE; release one cycle after completion.
// Backpressure: a held grant waits on ready_i (and rvalid_i for reads); other requests stay pending.
module iob_merge_arb #(
    parameter int N         = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                                 clk_i,
    input  logic                                 cke_i,
    input  logic                                 rst_i,
    input  logic [N-1:0]                         req_i,
    input  logic [N-1:0]                         wr_i,
    input  logic                                 ready_i,
    input  logic                                 rvalid_i,
    output logic [N-1:0]                         grant_o,
    output logic [$clog2(N)+($clog2(N)==0)-1:0]  sel_o,
    output logic                                 busy_o,
    output logic                                 timeout_o
);

    localparam int NBITS = $clog2(N) + ($clog2(N) == 0);
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NBITS-1:0]     ptr_q, ptr_d;
    logic [NBITS-1:0]     sel_q, sel_d;
    logic [N-1:0]         grant_q, grant_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 tmo_q, tmo_d;

    // Arbitration scratch: first requester at or after ptr, wrapping.
    logic                 found;
    logic [NBITS-1:0]     pick;
    logic [N-1:0]         pick_oh;
    logic [NBITS-1:0]     ptr_after;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 cur_req;
    logic                 cur_wr;
    logic                 rel;

    // Round-robin search: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[k] && (k >= int'(ptr_q))) begin
                found      = 1'b1;
                pick       = NBITS'(k);
                pick_oh    = '0;
                pick_oh[k] = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[k]) begin
                found      = 1'b1;
                pick       = NBITS'(k);
                pick_oh    = '0;
                pick_oh[k] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every release advances ptr past the granted index.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        wdog_d    = wdog_q;
        tmo_d     = 1'b0;
        rel       = 1'b0;
        cur_req   = req_i[sel_q];
        cur_wr    = wr_i[sel_q];
        wdog_inc  = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
        ptr_after = (int'(sel_q) >= N - 1) ? '0 : sel_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = pick_oh;
                    sel_d   = pick;
                end
            end
            GRANT: begin
                if (!cur_req) begin
                    // Manager withdrew before acceptance.
                    rel = 1'b1;
                end else if (ready_i) begin
                    if (cur_wr || rvalid_i) begin
                        rel = 1'b1;
                    end else begin
                        state_d = WAIT_R;
                        wdog_d  = '0;
                    end
                end
            end
            WAIT_R: begin
                if (rvalid_i) begin
                    rel = 1'b1;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == WD_MAX) begin
                        tmo_d = 1'b1;
                        rel   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase

        if (rel) begin
            state_d = IDLE;
            grant_d = '0;
            sel_d   = '0;
            ptr_d   = ptr_after;
        end
    end

    // State register: reset wins over clock enable; cke_i low freezes everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            wdog_q  <= '0;
            tmo_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant_o   = grant_q;
    assign sel_o     = sel_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = tmo_q;

endmodule

// File: tb/tb_iob_merge_arb.sv
module tb_iob_merge_arb;

    localparam int N  = 4;
    localparam int TW = 3;

    logic         clk = 1'b0;
    logic         cke;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] wr;
    logic         ready;
    logic         rvalid;
    logic [N-1:0] grant;
    logic [1:0]   sel;
    logic         busy;
    logic         tmo;

    int checks = 0;
    int errors = 0;

    iob_merge_arb #(.N(N), .TIMEOUT_W(TW)) dut (
        .clk_i     (clk),
        .cke_i     (cke),
        .rst_i     (rst),
        .req_i     (req),
        .wr_i      (wr),
        .ready_i   (ready),
        .rvalid_i  (rvalid),
        .grant_o   (grant),
        .sel_o     (sel),
        .busy_o    (busy),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic b, input logic t);
        checks++;
        assert ({grant, sel, busy, tmo} === {g, s, b, t})
        else begin
            errors++;
            $error("FAIL %s: got grant=%b sel=%0d busy=%b tmo=%b, expected grant=%b sel=%0d busy=%b tmo=%b",
                   tag, grant, sel, busy, tmo, g, s, b, t);
        end
    endtask

    initial begin
        cke = 1'b1; rst = 1'b1; req = '0; wr = '0; ready = 1'b0; rvalid = 1'b0;
        tick();
        tick();
        chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single write from manager 1.
        req = 4'b0010; wr = 4'b0010;
        tick();
        chk("wr_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        ready = 1'b1;
        tick();
        chk("wr_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // ptr is now 2: all four request, manager 2 wins first.
        req = 4'b1111; wr = 4'b1111; ready = 1'b0;
        tick();
        chk("ptr_after_wr", 4'b0100, 2'd2, 1'b1, 1'b0);
        ready = 1'b1;
        tick();
        chk("rr_idle_a", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk("rr_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        chk("rr_idle_b", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk("rr_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        chk("rr_idle_c", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk("rr_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        chk("rr_idle_d", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk("rr_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk("rr_idle_e", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = '0; wr = '0; ready = 1'b0;

        // Read from manager 2 (ptr=3 wraps to it), rvalid three cycles after acceptance.
        req = 4'b0100;
        tick();
        chk("rd_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        ready = 1'b1;
        tick();
        chk("rd_wait0", 4'b0100, 2'd2, 1'b1, 1'b0);
        ready = 1'b0; req = 4'b0001;
        tick();
        chk("rd_wait1", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk("rd_wait2", 4'b0100, 2'd2, 1'b1, 1'b0);
        rvalid = 1'b1;
        tick();
        chk("rd_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        rvalid = 1'b0;
        tick();
        chk("pend_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Zero-latency read: ready and rvalid together, straight back to IDLE.
        ready = 1'b1; rvalid = 1'b1;
        tick();
        chk("zl_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        ready = 1'b0; rvalid = 1'b0; req = '0;
        tick();
        chk("zl_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Timeout: read by manager 3, rvalid never comes; limit is 7 cycles.
        req = 4'b1000;
        tick();
        chk("to_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        ready = 1'b1;
        tick();
        chk("to_wait0", 4'b1000, 2'd3, 1'b1, 1'b0);
        ready = 1'b0; req = '0;
        for (int i = 0; i < 6; i++) tick();
        chk("to_wait6", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        chk("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
        req = 4'b1111; wr = 4'b1111;
        tick();
        chk("to_ptr", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Withdraw: manager 0 drops its request before ready.
        req = 4'b0000;
        tick();
        chk("wd_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0011;
        tick();
        chk("wd_ptr", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Reset during WAIT_R.
        wr = 4'b0000; ready = 1'b1;
        tick();
        chk("rst_wait", 4'b0010, 2'd1, 1'b1, 1'b0);
        ready = 1'b0; req = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b0011; wr = 4'b0011;
        tick();
        chk("rst_ptr", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Clock enable low freezes the held grant even with ready high.
        cke = 1'b0; ready = 1'b1;
        tick();
        chk("cke_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        cke = 1'b1;
        tick();
        chk("cke_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
